// File: rtl/psram_access_arbiter_pkg.sv
// psram_access_arbiter_pkg: shared state/port types, parameter defaults and counter helpers
package psram_access_arbiter_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        GRANT_WR = 4'b0010,
        GRANT_RD = 4'b0100,
        RELEASE  = 4'b1000
    } t_state;

    typedef enum logic {
        PORT_WR = 1'b0,
        PORT_RD = 1'b1
    } t_port;

    localparam int DEF_ADDR_WIDTH     = 21;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_MAX_RD_STREAK  = 4;
    localparam int DEF_GUARD_CYCLES   = 2;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // A down-counter loaded with n-1 reaches zero in its n-th counting cycle; n=0 acts as n=1.
    function automatic int load_value(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

    // One counter width serves both the guard and the timeout counts.
    function automatic int count_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/psram_access_arbiter_if.sv
// psram_access_arbiter_if: requester, reader and PSRAM-controller signals of the access arbiter
interface psram_access_arbiter_if
    import psram_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  mem_ready;
    logic                  wr_rq;
    logic                  wr_ack;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_rq;
    logic                  rd_ack;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cmd;
    logic                  mem_cmd_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_data_valid;
    logic                  timeout_err;

    // Arbiter side.
    modport slave (
        input  mem_ready, wr_rq, wr_addr, wr_en, wr_data, rd_rq, rd_addr, rd_en,
               mem_rd_data, mem_rd_data_valid,
        output wr_ack, rd_ack, rd_data, rd_data_valid, mem_addr, mem_cmd, mem_cmd_en,
               mem_wr_data, timeout_err
    );

    // Requesters plus controller side.
    modport master (
        output mem_ready, wr_rq, wr_addr, wr_en, wr_data, rd_rq, rd_addr, rd_en,
               mem_rd_data, mem_rd_data_valid,
        input  wr_ack, rd_ack, rd_data, rd_data_valid, mem_addr, mem_cmd, mem_cmd_en,
               mem_wr_data, timeout_err
    );

endinterface

// File: rtl/psram_access_arbiter_guard_counter.sv
// psram_access_arbiter_guard_counter: loadable down-counter with zero flag (guard gap and grant timeout)
module psram_access_arbiter_guard_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (load) count <= value;
        else if (dec && !zero) count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/psram_access_arbiter.sv
// psram_access_arbiter: shares one PSRAM controller port between the frame-upload writer and the
// display reader; read priority with a write-starvation streak limit and a guard gap between grants.
// Defining PSRAM_ARB_TIMEOUT_EN adds a grant-length timeout with timeout_err pulse and req lockout.
module psram_access_arbiter
    import psram_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MAX_RD_STREAK  = DEF_MAX_RD_STREAK,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                   clk,
    input logic                   reset_n,
    psram_access_arbiter_if.slave bus
);
    localparam int              CW         = count_width(GUARD_CYCLES, TIMEOUT_CYCLES);
    localparam int              SW         = $clog2(MAX_RD_STREAK + 2);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_RD_STREAK);
    localparam logic [CW-1:0]   GUARD_LOAD = CW'(load_value(GUARD_CYCLES));

    t_state        state, next_state;
    t_port         winner;
    logic [SW-1:0] streak;
    logic          grant_wr, grant_rd, wr_ok, rd_ok, start, tmo, tmo_err, guard_zero;

    assign grant_wr = (state == GRANT_WR);
    assign grant_rd = (state == GRANT_RD);
    assign start    = (state == IDLE) && bus.mem_ready && (wr_ok || rd_ok);
    assign winner   = (rd_ok && (!wr_ok || streak != STREAK_MAX)) ? PORT_RD : PORT_WR;

    psram_access_arbiter_guard_counter #(.WIDTH(CW)) u_guard (
        .clk     (clk),
        .reset_n (reset_n),
        .load    ((next_state == RELEASE) && (state != RELEASE)),
        .value   (GUARD_LOAD),
        .dec     (state == RELEASE),
        .zero    (guard_zero)
    );

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(load_value(TIMEOUT_CYCLES));
    logic tmo_zero, wr_blk, rd_blk;

    psram_access_arbiter_guard_counter #(.WIDTH(CW)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start),
        .value   (TIMEOUT_LOAD),
        .dec     (grant_wr || grant_rd),
        .zero    (tmo_zero)
    );

    assign tmo   = (grant_wr || grant_rd) && tmo_zero;
    assign wr_ok = bus.wr_rq && !wr_blk;
    assign rd_ok = bus.rd_rq && !rd_blk;

    // A timed-out requester stays locked out until its req has been seen low once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_blk  <= 1'b0;
            rd_blk  <= 1'b0;
            tmo_err <= 1'b0;
        end else begin
            wr_blk  <= (tmo && grant_wr) || (wr_blk && bus.wr_rq);
            rd_blk  <= (tmo && grant_rd) || (rd_blk && bus.rd_rq);
            tmo_err <= tmo;
        end
    end
`else
    assign tmo     = 1'b0;
    assign wr_ok   = bus.wr_rq;
    assign rd_ok   = bus.rd_rq;
    assign tmo_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next_state;
    end

    // Next state: grants are held until req drops (or times out); every grant ends through RELEASE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = start ? ((winner == PORT_RD) ? GRANT_RD : GRANT_WR) : IDLE;
            GRANT_WR: next_state = (!bus.wr_rq || tmo) ? RELEASE : GRANT_WR;
            GRANT_RD: next_state = (!bus.rd_rq || tmo) ? RELEASE : GRANT_RD;
            RELEASE:  next_state = guard_zero ? IDLE : RELEASE;
            default:  next_state = IDLE;
        endcase
    end

    // Read streak: counts reads granted over a waiting writer; a write grant or an idle writer clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) streak <= '0;
        else if (start && winner == PORT_WR) streak <= '0;
        else if (start && bus.wr_rq && streak != STREAK_MAX) streak <= streak + 1'b1;
        else if (state == RELEASE && guard_zero && !bus.wr_rq) streak <= '0;
    end

    // Outputs: acks and memory-side mux decoded from state; strobes reach the controller only from the owner.
    always_comb begin
        bus.wr_ack        = grant_wr;
        bus.rd_ack        = grant_rd;
        bus.mem_addr      = grant_wr ? bus.wr_addr : (grant_rd ? bus.rd_addr : ADDR_WIDTH'(0));
        bus.mem_cmd       = grant_wr;
        bus.mem_cmd_en    = (grant_wr && bus.wr_en) || (grant_rd && bus.rd_en);
        bus.mem_wr_data   = grant_wr ? bus.wr_data : DATA_WIDTH'(0);
        bus.rd_data       = bus.mem_rd_data;
        bus.rd_data_valid = bus.mem_rd_data_valid && (grant_rd || state == RELEASE);
        bus.timeout_err   = tmo_err;
    end

endmodule
